// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Front-end control for a stopwatch. It sits directly upstream of the seconds
// counter. The block does the following:
//   * It passes each raw button through a 2-flop synchroniser. It can also
//     debounce the button, then it edge-detects the accepted level. The result
//     is a one-cycle press pulse.
//   * It runs an IDLE / RUNNING / PAUSED state machine from those presses.
//   * It prescales clk into a one-cycle-per-second tick_en while RUNNING. The
//     partial second is kept across a pause.
//   * It emits a one-cycle count_clr when the reset button is pressed. The top
//     level folds it into the counter reset: counter rst_n = rst_n & ~count_clr.
//
// Build option:
//   STOPWATCH_CTRL_DEBOUNCE_EN - when defined, the accepted button level only
//   changes after DEBOUNCE_CYCLES consecutive cycles of disagreement with the
//   synchronised level. When undefined, the accepted level is the synchroniser
//   output, no debounce counters exist, and DEBOUNCE_CYCLES is ignored.
//
// Parameters:
//   TICK_DIV         clk cycles per tick_en pulse (>= 1)
//   DEBOUNCE_CYCLES  stable cycles before a button level is accepted (>= 1)
//
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous, active-low reset
//   btn_start  in   raw start/stop button, asynchronous, active-high
//   btn_reset  in   raw reset button, asynchronous, active-high
//   tick_en    out  one-cycle pulse per elapsed second while RUNNING
//   count_clr  out  one-cycle clear pulse, the cycle after a reset press
//   running    out  1 while the state is RUNNING
//   paused     out  1 while the state is PAUSED
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_start,
    input  logic btn_reset,
    output logic tick_en,
    output logic count_clr,
    output logic running,
    output logic paused
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    generate
        if (TICK_DIV < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
            $error("stopwatch_ctrl: TICK_DIV and DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    // Both buttons share one pipeline: bit 0 = start/stop, bit 1 = reset.
    logic [1:0]         btn_meta_p0;
    logic [1:0]         btn_sync_p1;
    logic [1:0]         btn_lvl;
    logic [1:0]         btn_prev;
    logic [1:0]         press_p3;
    logic               ss_press;
    logic               rst_press;
    state_t             state;
    state_t             state_nxt;
    logic [PRESC_W-1:0] presc;

    // ---- stage 0/1: two-flop synchroniser --------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_meta_p0 <= '0;
            btn_sync_p1 <= '0;
        end else begin
            btn_meta_p0 <= {btn_reset, btn_start};
            btn_sync_p1 <= btn_meta_p0;
        end
    end

    // ---- stage 2: accepted level -----------------------------------------
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      btn_lvl_p2;

    // The counter measures how long the synchronised level has disagreed
    // with the accepted level. Any cycle of agreement restarts it. Because
    // the counter is cleared by rst_n, a partial history seen before a reset
    // can never complete and cannot produce a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_lvl_p2 <= '0;
            db_cnt[0]  <= '0;
            db_cnt[1]  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_sync_p1[i] == btn_lvl_p2[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_lvl_p2[i] <= btn_sync_p1[i];
                    db_cnt[i]     <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_lvl = btn_lvl_p2;
`else
    assign btn_lvl = btn_sync_p1;
`endif

    // ---- stage 3: rising-edge detect -------------------------------------
    // A held button gives exactly one pulse. It re-arms only after the
    // accepted level has returned to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_prev <= '0;
            press_p3 <= '0;
        end else begin
            btn_prev <= btn_lvl;
            press_p3 <= btn_lvl & ~btn_prev;
        end
    end

    assign ss_press  = press_p3[0];
    assign rst_press = press_p3[1];

    // ---- stage 4: state machine ------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            running <= 1'b0;
            paused  <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUNNING);
            paused  <= (state_nxt == PAUSED);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_press) state_nxt = RUNNING;
            RUNNING: if (ss_press) state_nxt = PAUSED;
            PAUSED:  if (ss_press) state_nxt = RUNNING;
            default: state_nxt = IDLE;
        endcase
        // The reset button wins over a start/stop press in the same cycle.
        if (rst_press) begin
            state_nxt = IDLE;
        end
    end

    // ---- stage 4: prescaler and registered pulses ------------------------
    // The prescaler advances only in RUNNING and simply holds in PAUSED. This
    // is what carries the partial second across a pause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (rst_press) begin
            presc <= '0;
        end else begin
            case (state)
                RUNNING: presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                PAUSED:  presc <= presc;
                default: presc <= '0;
            endcase
        end
    end

    // The tick still fires when its boundary lines up with a start/stop press,
    // because that second did complete. It is suppressed under a reset press,
    // so tick_en and count_clr are never high in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_en   <= 1'b0;
            count_clr <= 1'b0;
        end else begin
            tick_en   <= (state == RUNNING) && (presc == PRESC_LAST) && !rst_press;
            count_clr <= rst_press;
        end
    end

endmodule
